branch_target_unit: RTL

//  Pipelined, parametrised next-PC calculator for the fetch/branch path.

---
 rtl/branch_target_unit_pkg.sv | 13 +
 rtl/branch_target_unit_sext.sv | 17 +
 rtl/branch_target_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/branch_target_unit_pkg.sv
// Shared definitions for the branch target unit: MODE encodings and default increment.
package branch_target_unit_pkg;

  typedef enum logic [1:0] {
    BT_REL = 2'b00,
    BT_ABS = 2'b01,
    BT_SEQ = 2'b10,
    BT_ILL = 2'b11
  } bt_mode_e;

  localparam int BT_PC_INC_DEFAULT = 4;

endpackage : branch_target_unit_pkg

// File: rtl/branch_target_unit_sext.sv
// Combinational sign-extend to OUT_W bits followed by a left shift of SHIFT bits.
module sext_shift #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2
) (
  input  logic [IN_W-1:0]  in_i,
  output logic [OUT_W-1:0] out_o
);

  logic [OUT_W-1:0] ext;

  // Extend first, then shift, so SHIFT=0 needs no zero-width replication.
  assign ext   = {{(OUT_W-IN_W){in_i[IN_W-1]}}, in_i};
  assign out_o = ext << SHIFT;

endmodule : sext_shift

// File: rtl/branch_target_unit.sv
// Two-stage next-PC calculator: stage 1 extends the offset and forms PC+PC_INC,
// stage 2 selects relative/absolute/sequential target and flags wrap and illegal mode.
module branch_target_unit
  import branch_target_unit_pkg::*;
#(
  parameter int OFFSET_W = 8,
  parameter int ADDR_W   = 32,
  parameter int SHIFT    = 2,
  parameter int PC_INC   = BT_PC_INC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [ADDR_W-1:0]   pc_i,
  input  logic [OFFSET_W-1:0] offset_i,
  input  logic [1:0]          mode_i,
  input  logic                flush_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [ADDR_W-1:0]   target_o,
  output logic [ADDR_W-1:0]   ext_offset_o,
  output logic                wrap_o,
  output logic                err_o
);

  if (OFFSET_W + SHIFT >= ADDR_W) begin : g_width_check
    $error("branch_target_unit: OFFSET_W+SHIFT (%0d) must be less than ADDR_W (%0d)",
           OFFSET_W + SHIFT, ADDR_W);
  end

  // Handshake: a transfer happens on a side whenever valid and ready are both high
  // at a rising edge; valid never depends on ready, and a held output stays stable.
  logic              s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0] s1_ext_q;
  logic [ADDR_W:0]   s1_pc4_q;
  bt_mode_e          s1_mode_q;

  logic              s2_valid_q, s2_valid_d;
  logic [ADDR_W-1:0] s2_target_q, s2_target_d;
  logic [ADDR_W-1:0] s2_ext_q, s2_ext_d;
  logic              s2_wrap_q, s2_wrap_d;
  logic              s2_err_q, s2_err_d;

  logic              in_fire, out_fire, s2_load, s1_advance;
  logic [ADDR_W-1:0] ext_in;
  logic [ADDR_W:0]   pc4_in;
  logic [ADDR_W+1:0] rel_sum;

  sext_shift #(
    .IN_W  (OFFSET_W),
    .OUT_W (ADDR_W),
    .SHIFT (SHIFT)
  ) u_sext (
    .in_i  (offset_i),
    .out_o (ext_in)
  );

  assign pc4_in = {1'b0, pc_i} + (ADDR_W+1)'(PC_INC);

  assign out_fire   = s2_valid_q & out_ready_i;
  assign s2_load    = s1_valid_q & (~s2_valid_q | out_ready_i);
  assign s1_advance = s2_load;
  assign in_ready_o = ~s1_valid_q | s1_advance;
  assign in_fire    = in_valid_i & in_ready_o;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush_i) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (in_fire)         s1_valid_d = 1'b1;
      else if (s1_advance) s1_valid_d = 1'b0;
      if (s2_load)         s2_valid_d = 1'b1;
      else if (out_fire)   s2_valid_d = 1'b0;
    end
  end

  // Relative sum is ADDR_W+2 bits: the top two bits are non-zero exactly when
  // the true result fell below zero or above 2^ADDR_W-1.
  assign rel_sum = {1'b0, s1_pc4_q} + {{2{s1_ext_q[ADDR_W-1]}}, s1_ext_q};

  always_comb begin
    s2_target_d = s1_pc4_q[ADDR_W-1:0];
    s2_ext_d    = s1_ext_q;
    s2_wrap_d   = s1_pc4_q[ADDR_W];
    s2_err_d    = 1'b0;
    case (s1_mode_q)
      BT_REL: begin
        s2_target_d = rel_sum[ADDR_W-1:0];
        s2_wrap_d   = |rel_sum[ADDR_W+1:ADDR_W];
      end
      BT_ABS: begin
        s2_target_d = s1_ext_q;
        s2_wrap_d   = 1'b0;
      end
      BT_ILL:  s2_err_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_ext_q    <= '0;
      s1_pc4_q    <= '0;
      s1_mode_q   <= BT_REL;
      s2_valid_q  <= 1'b0;
      s2_target_q <= '0;
      s2_ext_q    <= '0;
      s2_wrap_q   <= 1'b0;
      s2_err_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (in_fire && !flush_i) begin
        s1_ext_q  <= ext_in;
        s1_pc4_q  <= pc4_in;
        s1_mode_q <= bt_mode_e'(mode_i);
      end
      if (s2_load && !flush_i) begin
        s2_target_q <= s2_target_d;
        s2_ext_q    <= s2_ext_d;
        s2_wrap_q   <= s2_wrap_d;
        s2_err_q    <= s2_err_d;
      end
    end
  end

  assign out_valid_o  = s2_valid_q;
  assign target_o     = s2_target_q;
  assign ext_offset_o = s2_ext_q;
  assign wrap_o       = s2_wrap_q;
  assign err_o        = s2_err_q;

endmodule : branch_target_unit
